// File: rtl/core_dmem_arbiter.sv
// core_dmem_arbiter
// Shares one data-memory port between the core MEM stage (m0) and a
// secondary master (m1, e.g. page-table walker or debug port). Routing is
// combinational, so arbitration adds no cycles. A lock bit on a beat keeps
// ownership for the following beat, so locked read-modify-write sequences
// (LR/SC, AMO) cannot be split by the other master.
//
// Optional feature: define CORE_DMEM_ARB_RR_EN for round-robin selection of
// simultaneous requests in IDLE. Without it, m0 has fixed priority and no
// pointer register exists.
module core_dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // master 0 (core MEM stage)
  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic [AW-1:0]   m0_addr,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  input  logic            m0_lock,
  output logic [DW-1:0]   m0_rdata,
  output logic            m0_err,
  // master 1 (walker / debug)
  input  logic            m1_valid,
  output logic            m1_ready,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_write,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_lock,
  output logic [DW-1:0]   m1_rdata,
  output logic            m1_err,
  // downstream data-memory port
  output logic            dmem_valid,
  input  logic            dmem_ready,
  output logic [AW-1:0]   dmem_addr,
  output logic            dmem_write,
  output logic [DW-1:0]   dmem_wdata,
  output logic [DW/8-1:0] dmem_wstrb,
  input  logic [DW-1:0]   dmem_rdata,
  input  logic            dmem_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  logic sel_s;          // 0 = m0 routed, 1 = m1 routed
  logic route_valid_s;  // valid of the routed master
  logic route_lock_s;   // lock of the routed master
  logic done_s;         // routed transaction completes this cycle
  logic prefer_m1_s;    // tie-break for simultaneous requests in IDLE

`ifdef CORE_DMEM_ARB_RR_EN
  // Points at the master preferred on the next tie: the one not granted last.
  logic rr_q;
  logic rr_d;
  assign prefer_m1_s = rr_q;
`else
  assign prefer_m1_s = 1'b0;
`endif

  // Pick the routed master from the ownership state and the live requests.
  always_comb begin
    sel_s         = 1'b0;
    route_valid_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        route_valid_s = m0_valid | m1_valid;
        if (m0_valid && m1_valid) begin
          sel_s = prefer_m1_s;
        end else if (m1_valid) begin
          sel_s = 1'b1;
        end else begin
          // no request or m0 alone: m0's fields are presented
          sel_s = 1'b0;
        end
      end
      ST_OWN0: begin
        sel_s         = 1'b0;
        route_valid_s = m0_valid;
      end
      ST_OWN1: begin
        sel_s         = 1'b1;
        route_valid_s = m1_valid;
      end
      default: begin
        sel_s         = 1'b0;
        route_valid_s = 1'b0;
      end
    endcase
  end

  // Forward the routed master to the bus and fan completion back out.
  // Reset masks every handshake output so nothing completes while in reset.
  always_comb begin
    route_lock_s = sel_s ? m1_lock : m0_lock;
    dmem_valid   = route_valid_s & ~rst;
    dmem_addr    = sel_s ? m1_addr  : m0_addr;
    dmem_write   = sel_s ? m1_write : m0_write;
    dmem_wdata   = sel_s ? m1_wdata : m0_wdata;
    dmem_wstrb   = sel_s ? m1_wstrb : m0_wstrb;
    done_s       = dmem_valid & dmem_ready;
    m0_ready     = done_s & ~sel_s;
    m1_ready     = done_s & sel_s;
    m0_err       = m0_ready & dmem_err;
    m1_err       = m1_ready & dmem_err;
    m0_rdata     = dmem_rdata;
    m1_rdata     = dmem_rdata;
  end

  // Next ownership: hold through an outstanding beat or a locked completion,
  // release on an unlocked completion or when the owner drops valid.
  always_comb begin
    state_d = state_q;
`ifdef CORE_DMEM_ARB_RR_EN
    rr_d    = rr_q;
`endif
    if (!route_valid_s) begin
      state_d = ST_IDLE;
    end else if (done_s && !route_lock_s) begin
      state_d = ST_IDLE;
`ifdef CORE_DMEM_ARB_RR_EN
      rr_d    = ~sel_s;
`endif
    end else begin
      state_d = sel_s ? ST_OWN1 : ST_OWN0;
    end
  end

  // Ownership state register; reset drops any grant or lock immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CORE_DMEM_ARB_RR_EN
  // Round-robin pointer; starts preferring m0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

endmodule

// File: tb/tb_core_dmem_arbiter.sv
// Directed bench for core_dmem_arbiter. A transaction-level model (current
// owner as an integer, plus the preferred master) predicts every output each
// cycle; literal checks inside the scenarios pin the expected behaviour.
module tb_core_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            m0_valid, m0_ready, m0_write, m0_lock, m0_err;
  logic [AW-1:0]   m0_addr;
  logic [DW-1:0]   m0_wdata, m0_rdata;
  logic [DW/8-1:0] m0_wstrb;
  logic            m1_valid, m1_ready, m1_write, m1_lock, m1_err;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wdata, m1_rdata;
  logic [DW/8-1:0] m1_wstrb;
  logic            dmem_valid, dmem_ready, dmem_write, dmem_err;
  logic [AW-1:0]   dmem_addr;
  logic [DW-1:0]   dmem_wdata, dmem_rdata;
  logic [DW/8-1:0] dmem_wstrb;

  int errors = 0;
  int checks = 0;

  core_dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_write(m0_write), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_lock(m0_lock), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_write(m1_write), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_lock(m1_lock), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_addr(dmem_addr),
    .dmem_write(dmem_write), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int owner = -1;   // -1: nobody holds the port
  bit pref  = 1'b0; // master preferred on a tie (only used with round-robin)
  int r_m;
  bit v_m, d_m, l_m;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_dmem_valid", {63'd0, dmem_valid}, 64'd0);
      chk("rst_m0_ready", {63'd0, m0_ready}, 64'd0);
      chk("rst_m1_ready", {63'd0, m1_ready}, 64'd0);
      chk("rst_m0_err", {63'd0, m0_err}, 64'd0);
      chk("rst_m1_err", {63'd0, m1_err}, 64'd0);
      owner = -1;
      pref  = 1'b0;
    end else begin
      if (owner < 0) begin
        v_m = m0_valid | m1_valid;
        if (m0_valid && m1_valid) begin
`ifdef CORE_DMEM_ARB_RR_EN
          r_m = int'(pref);
`else
          r_m = 0;
`endif
        end else if (m1_valid) r_m = 1;
        else r_m = 0;
      end else begin
        r_m = owner;
        v_m = (owner == 1) ? m1_valid : m0_valid;
      end
      d_m = v_m & dmem_ready;
      l_m = (r_m == 1) ? m1_lock : m0_lock;
      chk("dmem_valid", {63'd0, dmem_valid}, {63'd0, v_m});
      chk("dmem_addr", {32'd0, dmem_addr}, {32'd0, (r_m == 1) ? m1_addr : m0_addr});
      chk("dmem_write", {63'd0, dmem_write}, {63'd0, (r_m == 1) ? m1_write : m0_write});
      chk("dmem_wdata", {32'd0, dmem_wdata}, {32'd0, (r_m == 1) ? m1_wdata : m0_wdata});
      chk("dmem_wstrb", {60'd0, dmem_wstrb}, {60'd0, (r_m == 1) ? m1_wstrb : m0_wstrb});
      chk("m0_ready", {63'd0, m0_ready}, {63'd0, d_m && r_m == 0});
      chk("m1_ready", {63'd0, m1_ready}, {63'd0, d_m && r_m == 1});
      chk("m0_err", {63'd0, m0_err}, {63'd0, d_m && r_m == 0 && dmem_err});
      chk("m1_err", {63'd0, m1_err}, {63'd0, d_m && r_m == 1 && dmem_err});
      chk("m0_rdata", {32'd0, m0_rdata}, {32'd0, dmem_rdata});
      chk("m1_rdata", {32'd0, m1_rdata}, {32'd0, dmem_rdata});
      if (d_m) begin
        if (l_m) owner = r_m;
        else begin
          owner = -1;
          pref  = (r_m == 0);
        end
      end else if (v_m) owner = r_m;
      else owner = -1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    m0_valid = 1'b0; m0_addr = 32'h0000_0100; m0_write = 1'b0;
    m0_wdata = 32'h0; m0_wstrb = 4'h0; m0_lock = 1'b0;
    m1_valid = 1'b0; m1_addr = 32'h0000_0200; m1_write = 1'b0;
    m1_wdata = 32'h0; m1_wstrb = 4'h0; m1_lock = 1'b0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0; dmem_err = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [2:0] g_exp;

  initial begin
    rst = 1'b1;
    clr();
    tick();
    // reset with a pending request: nothing reaches the bus
    m0_valid = 1'b1; dmem_ready = 1'b1;
    #3;
    chk("reset_blocks_valid", {63'd0, dmem_valid}, 64'd0);
    chk("reset_blocks_ready", {63'd0, m0_ready}, 64'd0);
    tick();
    rst = 1'b0;
    clr();
    tick();

    // idle: no request, m0 fields presented
    #3;
    chk("idle_valid", {63'd0, dmem_valid}, 64'd0);
    chk("idle_addr", {32'd0, dmem_addr}, 64'h0000_0100);
    tick();

    // single m0 read with 3-cycle downstream latency
    m0_valid = 1'b1; m0_addr = 32'h1000_0004;
    for (int i = 1; i <= 3; i++) begin
      dmem_ready = (i == 3);
      dmem_rdata = (i == 3) ? 32'hDEAD_BEEF : 32'h0;
      #3;
      chk("s1_m0_ready", {63'd0, m0_ready}, {63'd0, i == 3});
      chk("s1_m1_ready", {63'd0, m1_ready}, 64'd0);
      chk("s1_addr", {32'd0, dmem_addr}, 64'h1000_0004);
      if (i == 3) chk("s1_rdata", {32'd0, m0_rdata}, 64'hDEAD_BEEF);
      tick();
    end
    clr();
    tick();

    // simultaneous zero-wait requests
    do_reset();
`ifdef CORE_DMEM_ARB_RR_EN
    g_exp = 3'b010;
`else
    g_exp = 3'b000;
`endif
    m0_valid = 1'b1; m0_addr = 32'h0000_0A00;
    m1_valid = 1'b1; m1_addr = 32'h0000_0B00;
    dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("s2_m0_ready", {63'd0, m0_ready}, {63'd0, ~g_exp[i]});
      chk("s2_m1_ready", {63'd0, m1_ready}, {63'd0, g_exp[i]});
      tick();
    end
    clr();
    tick();

    // m1 write in progress; m0 arrives and must wait
    m1_valid = 1'b1; m1_write = 1'b1; m1_addr = 32'h0000_3000;
    m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
    m0_addr = 32'h0000_4000;
    tick();
    m0_valid = 1'b1;
    #3;
    chk("s3_addr_hold", {32'd0, dmem_addr}, 64'h0000_3000);
    chk("s3_m0_wait", {63'd0, m0_ready}, 64'd0);
    tick();
    dmem_ready = 1'b1;
    #3;
    chk("s3_m1_done", {63'd0, m1_ready}, 64'd1);
    chk("s3_wdata", {32'd0, dmem_wdata}, 64'h1234_5678);
    tick();
    m1_valid = 1'b0;
    #3;
    chk("s3_m0_addr", {32'd0, dmem_addr}, 64'h0000_4000);
    chk("s3_m0_done", {63'd0, m0_ready}, 64'd1);
    tick();
    clr();
    tick();

    // locked AMO from m0 while m1 requests throughout
    do_reset();
    m1_valid = 1'b1; m1_addr = 32'h0000_5000;
    m0_valid = 1'b1; m0_addr = 32'h0000_2000; m0_lock = 1'b1;
    dmem_ready = 1'b1;
    #3;
    chk("s4_read_done", {63'd0, m0_ready}, 64'd1);
    tick();
    m0_write = 1'b1; m0_lock = 1'b0; m0_wdata = 32'hCAFE_0001; m0_wstrb = 4'hF;
    dmem_ready = 1'b0;
    #3;
    chk("s4_locked_addr", {32'd0, dmem_addr}, 64'h0000_2000);
    chk("s4_m1_blocked", {63'd0, m1_ready}, 64'd0);
    tick();
    dmem_ready = 1'b1;
    #3;
    chk("s4_write_done", {63'd0, m0_ready}, 64'd1);
    chk("s4_m1_still", {63'd0, m1_ready}, 64'd0);
    tick();
    m0_valid = 1'b0; m0_write = 1'b0;
    #3;
    chk("s4_m1_granted", {63'd0, m1_ready}, 64'd1);
    chk("s4_m1_addr", {32'd0, dmem_addr}, 64'h0000_5000);
    tick();
    clr();
    tick();

    // error on an m1 load
    m1_valid = 1'b1; dmem_ready = 1'b1; dmem_err = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    #3;
    chk("s5_m1_err", {63'd0, m1_err}, 64'd1);
    chk("s5_m1_ready", {63'd0, m1_ready}, 64'd1);
    chk("s5_m0_err", {63'd0, m0_err}, 64'd0);
    tick();
    clr();
    tick();

    // reset while m1 owns the port mid-wait
    m1_valid = 1'b1; m1_addr = 32'h0000_6000;
    tick();
    rst = 1'b1; m0_valid = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("s6_rst_valid", {63'd0, dmem_valid}, 64'd0);
      chk("s6_rst_m0", {63'd0, m0_ready}, 64'd0);
      chk("s6_rst_m1", {63'd0, m1_ready}, 64'd0);
      tick();
    end
    rst = 1'b0;
    #3;
    chk("s6_m0_first", {63'd0, m0_ready}, 64'd1);
    chk("s6_m1_not", {63'd0, m1_ready}, 64'd0);
    tick();
    clr();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
